// File: rtl/ctrl_pipe_pkg.sv
// Purpose: shared control-bundle field indices, func_sel/opcode encodings and stage records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pipe_pkg;

  // Bundle widths as produced by the decoder
  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // Field positions inside each bundle
  localparam int EX_ALU_SRC    = 3;
  localparam int EX_REG_DST    = 2;
  localparam int MEM_WRITE     = 2;
  localparam int MEM_READ      = 1;
  localparam int MEM_BRANCH    = 0;
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // Conditional-execution selector; FS_RSVD behaves as FS_UNCOND
  typedef enum logic [1:0] {
    FS_UNCOND = 2'b00,
    FS_CARRY  = 2'b01,
    FS_ZERO   = 2'b10,
    FS_RSVD   = 2'b11
  } func_sel_e;

  // Opcodes shared with the decoder
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_SUB = 4'b1111;

  // ID/EX contents (destination register is carried beside it)
  typedef struct packed {
    logic              valid;
    logic [EX_W-1:0]   ex;
    logic [MEM_W-1:0]  mem;
    logic [WB_W-1:0]   wb;
    func_sel_e         func_sel;
  } idex_t;

  // EX/MEM contents: EX controls are consumed, branch zero is latched
  typedef struct packed {
    logic              valid;
    logic [MEM_W-1:0]  mem;
    logic [WB_W-1:0]   wb;
    logic              zero;
  } exmem_t;

  // MEM/WB contents
  typedef struct packed {
    logic              valid;
    logic [WB_W-1:0]   wb;
  } memwb_t;

  // Condition check for conditional execution against the architectural flags
  function automatic logic cond_ok(func_sel_e fs, logic carry, logic zero);
    logic ok;
    case (fs)
      FS_CARRY: ok = carry;
      FS_ZERO:  ok = zero;
      default:  ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage_reg.sv
// Purpose: generic pipeline register with synchronous reset and bubble (clear) input.
// Latency: 1 cycle.
// Backpressure: none; loads every edge, clear forces a zero (bubble) word.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Bubble substitution: an all-zero word is a bubble by construction
  always_comb begin
    data_d = clear ? '0 : d;
  end

  // Stage register, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Purpose: carries decoded control through ID/EX, EX/MEM, MEM/WB; owns flags, cond-writeback, branch.
// Latency: ID bundle shows on ex_* +1, mem_* +2, wb_* +3 cycles.
// Backpressure: stall bubbles ID/EX only; branch_taken bubbles ID/EX and EX/MEM; MEM/WB never held.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  id_valid,
  input  logic [3:0]            id_ex,
  input  logic [2:0]            id_mem,
  input  logic [1:0]            id_wb,
  input  logic [1:0]            id_func_sel,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic [1:0]            ex_alu_op,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch_taken,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  carry_flag,
  output logic                  zero_flag
);

  localparam int IDEX_W  = $bits(idex_t) + REG_ADDR_W;
  localparam int EXMEM_W = $bits(exmem_t) + REG_ADDR_W;
  localparam int MEMWB_W = $bits(memwb_t) + REG_ADDR_W;

  idex_t              id_bundle;
  idex_t              ex_st;
  exmem_t             ex_res;
  exmem_t             mem_st;
  memwb_t             wb_st;
  logic [IDEX_W-1:0]  idex_q;
  logic [EXMEM_W-1:0] exmem_q;
  logic [MEMWB_W-1:0] memwb_q;
  logic               idex_clear;
  logic               ex_cond_ok;
  logic               flag_upd;
  logic               carry_flag_d, carry_flag_q;
  logic               zero_flag_d, zero_flag_q;

  // Branch resolves in MEM from the zero result latched when it left EX
  assign branch_taken = mem_st.valid & mem_st.mem[MEM_BRANCH] & mem_st.zero;

  // ID bundle normalisation: reserved func_sel collapses to unconditional
  always_comb begin
    id_bundle.valid    = 1'b1;
    id_bundle.ex       = id_ex;
    id_bundle.mem      = id_mem;
    id_bundle.wb       = id_wb;
    id_bundle.func_sel = (id_func_sel == FS_RSVD) ? FS_UNCOND : func_sel_e'(id_func_sel);
  end

  // Flush outranks stall; both simply bubble ID/EX
  assign idex_clear = branch_taken | stall | ~id_valid;

  ctrl_stage_reg #(.W(IDEX_W)) u_idex (
    .clk   (clk),
    .reset (reset),
    .clear (idex_clear),
    .d     ({id_bundle, id_rd}),
    .q     (idex_q)
  );

  assign {ex_st, ex_rd} = idex_q;

  // EX resolution: conditional ops write iff their flag holds; a failed one keeps
  // its slot (valid) but loses reg_write and all memory/branch side effects
  always_comb begin
    ex_cond_ok   = cond_ok(ex_st.func_sel, carry_flag_q, zero_flag_q);
    ex_res.valid = ex_st.valid;
    ex_res.mem   = ex_cond_ok ? ex_st.mem : '0;
    ex_res.wb    = ex_st.wb;
    if (ex_st.func_sel != FS_UNCOND) begin
      ex_res.wb[WB_REG_WRITE] = ex_cond_ok;
    end
    ex_res.zero  = ex_st.valid & alu_zero;
  end

  ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
    .clk   (clk),
    .reset (reset),
    .clear (branch_taken),
    .d     ({ex_res, ex_rd}),
    .q     (exmem_q)
  );

  assign {mem_st, mem_rd} = exmem_q;

  ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d     ({mem_st.valid, mem_st.wb, mem_rd}),
    .q     (memwb_q)
  );

  assign {wb_st, wb_rd} = memwb_q;

  // Flags follow executed ALU-only instructions that are not being squashed
  always_comb begin
    flag_upd     = ex_st.valid & ex_cond_ok & ~ex_st.mem[MEM_WRITE] &
                   ~ex_st.mem[MEM_BRANCH] & ~ex_st.mem[MEM_READ] & ~branch_taken;
    carry_flag_d = carry_flag_q;
    zero_flag_d  = zero_flag_q;
    if (flag_upd) begin
      carry_flag_d = alu_carry;
      zero_flag_d  = alu_zero;
    end
  end

  // Architectural flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
    end else begin
      carry_flag_q <= carry_flag_d;
      zero_flag_q  <= zero_flag_d;
    end
  end

  assign ex_valid      = ex_st.valid;
  assign ex_alu_src    = ex_st.ex[EX_ALU_SRC];
  assign ex_reg_dst    = ex_st.ex[EX_REG_DST];
  assign ex_alu_op     = ex_st.ex[1:0];
  assign mem_valid     = mem_st.valid;
  assign mem_read      = mem_st.mem[MEM_READ];
  assign mem_write     = mem_st.mem[MEM_WRITE];
  assign wb_valid      = wb_st.valid;
  assign wb_reg_write  = wb_st.wb[WB_REG_WRITE];
  assign wb_mem_to_reg = wb_st.wb[WB_MEM_TO_REG];
  assign carry_flag    = carry_flag_q;
  assign zero_flag     = zero_flag_q;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decoder's control bundle (ex[3:0], mem[2:0], wb[1:0], func_sel[1:0]).
- Latches the decoded bundle at ID/EX, carries it through EX/MEM and MEM/WB, and drives per-stage enables.
- Owns the carry/zero flag registers and resolves conditional writeback (func_sel) and branch-taken.
- Handles load-use stall bubbles and branch flush for the 4-stage back end (ID→EX→MEM→WB).

Parameters:
REG_ADDR_W, 3, width of destination register address carried alongside control.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  load-use hazard: insert bubble into ID/EX this edge
id_valid  in  1  ID holds a real instruction
id_ex  in  4  [3]=alu_src_imm, [2]=reg_dst, [1:0]=alu_op (00 add, 01 sub)
id_mem  in  3  [2]=mem_write, [1]=mem_read, [0]=branch
id_wb  in  2  [1]=reg_write, [0]=mem_to_reg
id_func_sel  in  2  00 unconditional, 01 exec-if-carry, 10 exec-if-zero, 11 reserved (=00)
id_rd  in  REG_ADDR_W  destination register
alu_carry  in  1  EX-stage ALU carry out (same cycle)
alu_zero  in  1  EX-stage ALU zero result (same cycle)
ex_valid, ex_alu_src, ex_reg_dst  out  1 each  EX-stage controls
ex_alu_op  out  2  EX-stage ALU op
mem_valid, mem_read, mem_write  out  1 each  MEM-stage controls
branch_taken  out  1  MEM-stage branch & latched zero; combinational from EX/MEM
wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls
ex_rd, mem_rd, wb_rd  out  REG_ADDR_W each  dest per stage (for forwarding)
carry_flag, zero_flag  out  1 each  architectural flag registers

Behaviour:
- Reset: all pipeline registers, valids, controls, rd fields, carry_flag and zero_flag go to 0 on the first rising edge with reset=1. Reset mid-operation discards all in-flight instructions.
- Bubble: valid=0 and every control bit 0, rd=0.
- Latency: bundle at ID in cycle N appears on ex_* in N+1, mem_* in N+2, wb_* in N+3, absent stall or flush.
- ID/EX load:
  - flush (branch_taken) or stall or !id_valid → bubble.
  - Otherwise capture id_*; func_sel 11 is stored as 00.
- EX resolution, combinational in EX and captured into EX/MEM:
  - cond_ok = 1 for func_sel 00; carry_flag for 01; zero_flag for 10.
  - eff_reg_write = (func_sel==00) ? ex wb[1] : cond_ok. Conditional ops write only when their flag holds, independent of id_wb[1].
  - Suppressed conditional (cond_ok=0): EX/MEM captures valid=1 with reg_write=0 and mem/branch bits 0.
- EX/MEM load:
  - branch_taken=1 → bubble (squashes the younger instruction in EX).
  - Otherwise capture the EX stage with eff_reg_write, plus latched zero = alu_zero.
- MEM/WB: always captures EX/MEM unconditionally; never stalled or flushed.
- Flag update at the EX→MEM edge, only when ex_valid & cond_ok & !mem_write & !branch & !mem_read & !branch_taken:
  - carry_flag ← alu_carry; zero_flag ← alu_zero.
  - The next instruction in EX sees the updated flags, so no flag forwarding is needed.
- branch_taken = mem_valid & mem_branch & latched zero. Same cycle it squashes ID/EX and EX/MEM at the next edge.
- Simultaneous stall and branch_taken: flush wins; both ID/EX and EX/MEM become bubbles.
- The stall input does not freeze EX/MEM or MEM/WB. Holding the IF/ID register is the fetch unit's job.

Decomposition:
- Shared package holds:
  - field-index constants (EX_ALU_SRC=3, EX_REG_DST=2, MEM_WRITE=2, MEM_READ=1, MEM_BRANCH=0, WB_REG_WRITE=1, WB_MEM_TO_REG=0)
  - func_sel encodings FS_UNCOND/FS_CARRY/FS_ZERO
  - opcode constants (ADD 0000, ADI 0001, LW 0100, SW 0101, BEQ 1100, SUB 1111), also used by the decoder.
- One sub-module: ctrl_stage_reg, a parameterised-width pipeline register with synchronous reset and a bubble (clear) input. It is instantiated three times.

Test Plan:
- Reset: reset=1 for 2 cycles with id_valid=1 and a bundle present → all outputs 0; first bundle after release appears on ex_* exactly 1 cycle later.
- Pipeline walk: LW (ex=1000, mem=010, wb=11, rd=3), then ADD (0100/000/10, rd=5) → mem_read=1 at N+2, wb_mem_to_reg=1 and wb_rd=3 at N+3, wb_reg_write=1 and wb_rd=5 at N+4.
- Conditional write:
  - SUB with alu_carry=1, then ADD func_sel=01 → wb_reg_write=1.
  - Repeat with alu_carry=0 → wb_reg_write=0, wb_valid=1, carry_flag stays 0.
- Stall: stall=1 for one cycle with ADI at ID → ex_valid=0 next cycle; the instruction already in EX still reaches mem_* one cycle later.
- Branch: BEQ (0101/001/00) with alu_zero=1, two ADDs behind → branch_taken=1 at N+2; both ADDs become bubbles; zero flag unchanged by BEQ.
- Stall+flush same cycle, and reset asserted while LW is in MEM → bubbles in ID/EX and EX/MEM; reset clears wb_* and both flags next edge.
